// File: rtl/peripheral_bridge_pkg.sv
// Shared types and helpers for the peripheral register bridge.
//   bridge_state_t : transaction FSM states
//   onehot()       : index -> one-hot select vector (MAX_SEL_W wide; callers
//                    size-cast the result down to their own strobe width)
package peripheral_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    CAPTURE = 2'd2,
    RESPOND = 2'd3
  } bridge_state_t;

  // Largest strobe vector any bridge instance may request.
  localparam int unsigned MAX_SEL_W = 256;
  localparam int unsigned SEL_IDX_W = $clog2(MAX_SEL_W);

  // One-hot vector with bit 'addr' set when 'en' is high; all zeros otherwise.
  function automatic logic [MAX_SEL_W-1:0] onehot(input logic [31:0] addr, input logic en);
    logic [MAX_SEL_W-1:0] vec;
    vec = '0;
    if (en && (addr < MAX_SEL_W)) vec[addr[SEL_IDX_W-1:0]] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/peripheral_addr_decoder.sv
// Combinational address decoder for the register bridge.
//   addr_i     : word address (full request width)
//   data_out_i : flattened register read data, register i at [i*BUSWIDTH +: BUSWIDTH]
//   in_range_o : addr_i < REGS, compared over the full address width
//   sel_o      : one-hot register select, all zeros when out of range
//   rdata_o    : selected register data, zero when out of range
module peripheral_addr_decoder
  import peripheral_bridge_pkg::*;
#(
  parameter int BUSWIDTH     = 32,
  parameter int REGS         = 4,
  parameter int ADDRWIDTH    = 16,
  parameter int POWEROF2REGS = 4
) (
  input  logic [ADDRWIDTH-1:0]             addr_i,
  input  logic [POWEROF2REGS*BUSWIDTH-1:0] data_out_i,
  output logic                             in_range_o,
  output logic [POWEROF2REGS-1:0]          sel_o,
  output logic [BUSWIDTH-1:0]              rdata_o
);

  localparam int IDX_W = (POWEROF2REGS > 1) ? $clog2(POWEROF2REGS) : 1;
  localparam logic [ADDRWIDTH:0] REGS_LIMIT = (ADDRWIDTH + 1)'(REGS);

  logic [IDX_W-1:0] idx;

  // The range check sees every address bit, so high addresses never alias
  // onto a low register through the truncated index below.
  assign in_range_o = ({1'b0, addr_i} < REGS_LIMIT);
  assign idx        = addr_i[IDX_W-1:0];
  assign sel_o      = POWEROF2REGS'(onehot(32'(idx), in_range_o));
  assign rdata_o    = in_range_o ? data_out_i[idx*BUSWIDTH +: BUSWIDTH] : '0;

endmodule

// File: rtl/peripheral_register_bridge.sv
// Bus-side initiator for the peripheral register interface.
// Turns single-beat valid/ready requests into one-cycle write/read strobes on
// exactly one register, captures read data one cycle after the strobe, and
// returns it on a valid/ready response channel.
//   clk, reset (async, active low)
//   req_valid/req_ready/req_write/req_addr/req_wdata : request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_error          : response channel
//   reg_data_in, reg_write_en, reg_read_en           : register block drive
//   reg_data_out                                     : flattened register read data
// Timeline: accept at edge N, strobe in cycle N+1, capture in N+2, respond from N+3.
module peripheral_register_bridge
  import peripheral_bridge_pkg::*;
#(
  parameter int BUSWIDTH     = 32,
  parameter int REGS         = 4,
  parameter int ADDRWIDTH    = 16,
  parameter int POWEROF2REGS = (REGS > 1) ? 2 ** $clog2(REGS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDRWIDTH-1:0]             req_addr,
  input  logic [BUSWIDTH-1:0]              req_wdata,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [BUSWIDTH-1:0]              rsp_rdata,
  output logic                             rsp_error,
  output logic [BUSWIDTH-1:0]              reg_data_in,
  output logic [POWEROF2REGS-1:0]          reg_write_en,
  output logic [POWEROF2REGS-1:0]          reg_read_en,
  input  logic [POWEROF2REGS*BUSWIDTH-1:0] reg_data_out
);

  bridge_state_t               state_q, state_d;
  logic [ADDRWIDTH-1:0]        addr_q, addr_d;
  logic                        write_q, write_d;
  logic                        in_range_q, in_range_d;
  logic [BUSWIDTH-1:0]         data_in_q, data_in_d;
  logic [POWEROF2REGS-1:0]     wr_en_q, wr_en_d;
  logic [POWEROF2REGS-1:0]     rd_en_q, rd_en_d;
  logic [BUSWIDTH-1:0]         rdata_q, rdata_d;
  logic                        error_q, error_d;

  logic                        handshake;
  logic [ADDRWIDTH-1:0]        dec_addr;
  logic                        dec_in_range;
  logic [POWEROF2REGS-1:0]     dec_sel;
  logic [BUSWIDTH-1:0]         dec_rdata;

  // One decoder serves both phases: in IDLE it decodes the incoming address
  // so the strobe can be registered at the accept edge; afterwards it decodes
  // the latched address for the read-data capture.
  assign dec_addr = (state_q == IDLE) ? req_addr : addr_q;

  peripheral_addr_decoder #(
    .BUSWIDTH    (BUSWIDTH),
    .REGS        (REGS),
    .ADDRWIDTH   (ADDRWIDTH),
    .POWEROF2REGS(POWEROF2REGS)
  ) u_decoder (
    .addr_i    (dec_addr),
    .data_out_i(reg_data_out),
    .in_range_o(dec_in_range),
    .sel_o     (dec_sel),
    .rdata_o   (dec_rdata)
  );

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESPOND);
  assign handshake = req_valid && req_ready;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    in_range_d = in_range_q;
    data_in_d  = data_in_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    wr_en_d    = '0;
    rd_en_d    = '0;

    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          addr_d     = req_addr;
          write_d    = req_write;
          in_range_d = dec_in_range;
          if (req_write) begin
            data_in_d = req_wdata;
            wr_en_d   = dec_sel;
          end else begin
            rd_en_d   = dec_sel;
          end
          state_d = STROBE;
        end
      end
      STROBE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // The register block updates data_out one cycle after read_en,
        // so it is sampled here rather than during STROBE.
        rdata_d = (!write_q && in_range_q) ? dec_rdata : '0;
        error_d = !in_range_q;
        state_d = RESPOND;
      end
      RESPOND: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      in_range_q <= 1'b0;
      data_in_q  <= '0;
      wr_en_q    <= '0;
      rd_en_q    <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      in_range_q <= in_range_d;
      data_in_q  <= data_in_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      rdata_q    <= rdata_d;
      error_q    <= error_d;
    end
  end

  assign reg_data_in  = data_in_q;
  assign reg_write_en = wr_en_q;
  assign reg_read_en  = rd_en_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_error    = error_q;

endmodule

// File: tb/tb_peripheral_register_bridge.sv
// Self-checking bench for peripheral_register_bridge: a directed vector table,
// hand-written reset sequences, and random transactions scored against a
// register-array reference model.
module tb_peripheral_register_bridge;

  localparam int BW   = 32;
  localparam int REGS = 4;
  localparam int AW   = 16;
  localparam int P2   = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                req_valid, req_ready, req_write;
  logic [AW-1:0]       req_addr;
  logic [BW-1:0]       req_wdata;
  logic                rsp_valid, rsp_ready, rsp_error;
  logic [BW-1:0]       rsp_rdata;
  logic [BW-1:0]       reg_data_in;
  logic [P2-1:0]       reg_write_en, reg_read_en;
  logic [P2*BW-1:0]    reg_data_out;

  peripheral_register_bridge #(
    .BUSWIDTH(BW), .REGS(REGS), .ADDRWIDTH(AW), .POWEROF2REGS(P2)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .reg_data_in(reg_data_in), .reg_write_en(reg_write_en),
    .reg_read_en(reg_read_en), .reg_data_out(reg_data_out)
  );

  always #5 clk = ~clk;

  // Register block: write on write_en, data_out refreshed one cycle after read_en.
  logic [BW-1:0] env_mem  [P2] = '{32'h1000_0000, 32'h1234_5678, 32'h1000_0002, 32'h1000_0003};
  logic [BW-1:0] env_dout [P2] = '{32'hBAD0_0000, 32'hBAD0_0001, 32'hBAD0_0002, 32'hBAD0_0003};

  for (genvar g = 0; g < P2; g++) begin : g_dout
    assign reg_data_out[g*BW +: BW] = env_dout[g];
  end

  always @(posedge clk) begin
    for (int i = 0; i < P2; i++) begin
      if (reg_write_en[i]) env_mem[i]  <= reg_data_in;
      if (reg_read_en[i])  env_dout[i] <= env_mem[i];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe monitor, sampled at the edge that ends each strobe cycle.
  int            wr_strobes = 0;
  int            rd_strobes = 0;
  logic [P2-1:0] last_wr_vec = '0;
  logic [P2-1:0] last_rd_vec = '0;
  logic [BW-1:0] last_wr_data = '0;

  always @(posedge clk) begin
    if (reset && (|reg_write_en || |reg_read_en)) begin
      check("strobe_onehot", 64'($onehot({reg_write_en, reg_read_en})), 64'd1);
      if (|reg_write_en) begin
        wr_strobes++;
        last_wr_vec  = reg_write_en;
        last_wr_data = reg_data_in;
      end
      if (|reg_read_en) begin
        rd_strobes++;
        last_rd_vec = reg_read_en;
      end
    end
  end

  // Reference model: register contents and the last write data presented.
  logic [BW-1:0] model_mem [P2] = '{32'h1000_0000, 32'h1234_5678, 32'h1000_0002, 32'h1000_0003};
  logic [BW-1:0] cur_data_in = '0;

  // Drives one transaction starting just after a negedge and returns just after
  // the negedge of the cycle following the response handshake.
  task automatic run_txn(input string name, input logic wr, input logic [AW-1:0] addr,
                         input logic [BW-1:0] wdata, input int hold,
                         input logic exp_err, input logic [BW-1:0] exp_rdata);
    int            wr0, rd0, lat;
    bit            got;
    logic [BW-1:0] rdata_seen;
    logic          err_seen;
    logic [P2-1:0] exp_vec;
    wr0 = wr_strobes;
    rd0 = rd_strobes;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    check({name, ":req_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    // Scramble fields after the handshake; only the accepted values matter.
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = AW'($urandom); req_wdata = $urandom;
    if (wr) cur_data_in = wdata;
    got = 0; lat = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; lat = c; end
    end
    check({name, ":latency"}, 64'(lat), 64'd3);
    if (got) begin
      check({name, ":rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
      check({name, ":error"}, 64'(rsp_error), 64'(exp_err));
      rdata_seen = rsp_rdata;
      err_seen   = rsp_error;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check({name, ":hold_stable"}, 64'({rsp_valid, req_ready, rsp_error, rsp_rdata}),
              64'({1'b1, 1'b0, err_seen, rdata_seen}));
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      check({name, ":after_rsp"}, 64'({req_ready, rsp_valid}), 64'(2'b10));
    end
    check({name, ":wr_strobes"}, 64'(wr_strobes - wr0), 64'(wr && !exp_err));
    check({name, ":rd_strobes"}, 64'(rd_strobes - rd0), 64'(!wr && !exp_err));
    exp_vec = P2'(1) << addr[1:0];
    if (wr && !exp_err) begin
      check({name, ":wr_vec"}, 64'(last_wr_vec), 64'(exp_vec));
      check({name, ":wr_data"}, 64'(last_wr_data), 64'(wdata));
    end
    if (!wr && !exp_err) check({name, ":rd_vec"}, 64'(last_rd_vec), 64'(exp_vec));
    check({name, ":data_in"}, 64'(reg_data_in), 64'(cur_data_in));
  endtask

  typedef struct {
    string         name;
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
    int            hold;
    logic          exp_err;
    logic [BW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{"wr2",      1'b1, 16'd2,      32'hDEAD_BEEF, 0,  1'b0, 32'h0};
    vecs[1]  = '{"rd1",      1'b0, 16'd1,      32'h0,         0,  1'b0, 32'h1234_5678};
    vecs[2]  = '{"rd7",      1'b0, 16'd7,      32'h0,         0,  1'b1, 32'h0};
    vecs[3]  = '{"wr4",      1'b1, 16'h0004,   32'hCAFE_F00D, 0,  1'b1, 32'h0};
    vecs[4]  = '{"rd0_a",    1'b0, 16'd0,      32'h0,         0,  1'b0, 32'h1000_0000};
    vecs[5]  = '{"wr8",      1'b1, 16'd8,      32'h1111_2222, 0,  1'b1, 32'h0};
    vecs[6]  = '{"rd0_b",    1'b0, 16'd0,      32'h0,         0,  1'b0, 32'h1000_0000};
    vecs[7]  = '{"wr3_hold", 1'b1, 16'd3,      32'hA5A5_A5A5, 10, 1'b0, 32'h0};
    vecs[8]  = '{"rd3",      1'b0, 16'd3,      32'h0,         2,  1'b0, 32'hA5A5_A5A5};
    vecs[9]  = '{"rd2",      1'b0, 16'd2,      32'h0,         0,  1'b0, 32'hDEAD_BEEF};
    vecs[10] = '{"rdffff",   1'b0, 16'hFFFF,   32'h0,         0,  1'b1, 32'h0};
    vecs[11] = '{"wr1",      1'b1, 16'd1,      32'h0F0F_0F0F, 1,  1'b0, 32'h0};
    vecs[12] = '{"rd1_b",    1'b0, 16'd1,      32'h0,         0,  1'b0, 32'h0F0F_0F0F};

    // Reset held with a pending request: the bridge must stay quiet.
    reset = 1'b0; rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'd2; req_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset_ctrl", 64'({req_ready, rsp_valid, rsp_error, reg_write_en, reg_read_en}),
            64'({1'b1, 1'b0, 1'b0, 4'b0, 4'b0}));
      check("reset_data", 64'({rsp_rdata, reg_data_in}), 64'd0);
    end
    req_valid = 1'b0;
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("idle_no_strobe", 64'(wr_strobes + rd_strobes), 64'd0);

    foreach (vecs[i]) begin
      run_txn(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].hold,
              vecs[i].exp_err, vecs[i].exp_rdata);
      if (vecs[i].wr && vecs[i].addr < REGS) model_mem[vecs[i].addr[1:0]] = vecs[i].wdata;
    end

    // Reset pulsed during the strobe cycle of a write.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'd0; req_wdata = 32'h7777_7777;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("midrst_strobe", 64'(reg_write_en), 64'(4'b0001));
    #2 reset = 1'b0;
    #1 check("midrst_drop", 64'({reg_write_en, reg_read_en}), 64'd0);
    @(posedge clk); #2 reset = 1'b1;
    cur_data_in = '0;
    check("midrst_data_in", 64'(reg_data_in), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", 64'({req_ready, rsp_valid}), 64'(2'b10));
    end
    run_txn("post_rst_wr0", 1'b1, 16'd0, 32'h1357_9BDF, 0, 1'b0, 32'h0);
    model_mem[0] = 32'h1357_9BDF;
    run_txn("post_rst_rd0", 1'b0, 16'd0, 32'h0, 0, 1'b0, 32'h1357_9BDF);

    // Random traffic against the model.
    for (int n = 0; n < 40; n++) begin
      logic          wr, err;
      logic [AW-1:0] addr;
      logic [BW-1:0] wdata, exp_rdata;
      wr    = 1'($urandom_range(0, 1));
      addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 9));
      wdata = $urandom;
      err   = (addr >= REGS);
      exp_rdata = (!wr && !err) ? model_mem[addr[1:0]] : '0;
      run_txn("rand", wr, addr, wdata, int'($urandom_range(0, 3)), err, exp_rdata);
      if (wr && !err) model_mem[addr[1:0]] = wdata;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
